// File: rtl/acc_pkg.sv
// Shared types and constants for the classification-accelerator sequencer.
package acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      FIN   = 2'd3
   } state_t;

   localparam int          LIMIT_W  = 4;
   localparam logic [3:0]  ERR_PRED = 4'hF;
   localparam int          SCORE_W  = 16;

   // Most-negative two's-complement value for an arbitrary score width.
   function automatic logic [63:0] most_neg(input int w);
      return 64'd1 << (w - 1);
   endfunction

   localparam logic [SCORE_W-1:0] MOST_NEG_SCORE = SCORE_W'(most_neg(SCORE_W));

endpackage

// File: rtl/acc_argmax_tracker.sv
// Running argmax over signed scores; strict greater-than so ties keep the lower index.
module acc_argmax_tracker
   import acc_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int PRED_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              valid,
   input  logic [DATA_W-1:0] score,
   input  logic [PRED_W-1:0] index,
   output logic [PRED_W-1:0] best_idx
);

   localparam logic [DATA_W-1:0] MIN_SCORE = DATA_W'(most_neg(DATA_W));

   logic [DATA_W-1:0] best_score;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         best_score <= MIN_SCORE;
         best_idx   <= '0;
      end else if (clear) begin
         best_score <= MIN_SCORE;
         best_idx   <= '0;
      end else if (valid && ($signed(score) > $signed(best_score))) begin
         best_score <= score;
         best_idx   <= index;
      end
   end

endmodule

// File: rtl/acc_sequencer.sv
// Issues one engine job per class for an ACC instruction and returns the argmax on predict.
// Optional ACC_SEQ_PERF_EN adds perf_cycles / perf_drops counters.
module acc_sequencer
   import acc_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int NUM_CLASS = 10,
   parameter int PRED_W    = 4,
   parameter int TIMEOUT   = 1023
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              acc_req,
   input  logic [DATA_W-1:0] rm_i,
   input  logic [DATA_W-1:0] rn_i,
   output logic              acc_done,
   output logic [PRED_W-1:0] predict,
   output logic              busy,
   output logic              err,
   output logic              eng_start,
   output logic [PRED_W-1:0] eng_class,
   output logic [DATA_W-1:0] eng_base,
   input  logic              eng_valid,
   input  logic [DATA_W-1:0] eng_score
`ifdef ACC_SEQ_PERF_EN
  ,output logic [15:0]       perf_cycles,
   output logic [7:0]        perf_drops
`endif
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_t            state;
   logic [PRED_W-1:0] cls;
   logic [PRED_W-1:0] lim;
   logic [TMO_W-1:0]  tmo;
   logic [PRED_W-1:0] req_lim;
   logic [PRED_W-1:0] best_idx;
   logic              accept;
   logic              trk_vld;

   // Only the low nibble of Rn carries the class count.
   wire unused_rn = &{1'b0, rn_i[DATA_W-1:LIMIT_W]};

   assign accept  = (state == IDLE) && acc_req;
   assign trk_vld = (state == WAIT) && eng_valid;

   always_comb begin
      req_lim = PRED_W'(NUM_CLASS);
      if ((rn_i[LIMIT_W-1:0] != '0) && (rn_i[LIMIT_W-1:0] <= LIMIT_W'(NUM_CLASS)))
         req_lim = PRED_W'(rn_i[LIMIT_W-1:0]);
   end

   acc_argmax_tracker #(.DATA_W(DATA_W), .PRED_W(PRED_W)) u_argmax (
      .clk_i    (clk_i),
      .rst_n    (rst_n),
      .clear    (accept),
      .valid    (trk_vld),
      .score    (eng_score),
      .index    (cls),
      .best_idx (best_idx)
   );

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cls       <= '0;
         lim       <= '0;
         tmo       <= '0;
         acc_done  <= 1'b0;
         predict   <= '0;
         busy      <= 1'b0;
         err       <= 1'b0;
         eng_start <= 1'b0;
         eng_class <= '0;
         eng_base  <= '0;
      end else begin
         eng_start <= 1'b0;
         case (state)
            IDLE: begin
               if (acc_req) begin
                  eng_base  <= rm_i;
                  lim       <= req_lim;
                  acc_done  <= 1'b0;
                  err       <= 1'b0;
                  busy      <= 1'b1;
                  cls       <= '0;
                  eng_class <= '0;
                  eng_start <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               tmo   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               // A score arriving on the expiry cycle takes priority over the timeout.
               if (eng_valid) begin
                  if (cls == lim - PRED_W'(1)) begin
                     state <= FIN;
                  end else begin
                     cls       <= cls + PRED_W'(1);
                     eng_class <= cls + PRED_W'(1);
                     eng_start <= 1'b1;
                     state     <= ISSUE;
                  end
               end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  state <= FIN;
               end else begin
                  tmo <= tmo + TMO_W'(1);
               end
            end
            FIN: begin
               predict  <= err ? PRED_W'(ERR_PRED) : best_idx;
               acc_done <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ACC_SEQ_PERF_EN
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles <= '0;
         perf_drops  <= '0;
      end else begin
         if (accept)
            perf_cycles <= '0;
         else if ((state != IDLE) && (perf_cycles != '1))
            perf_cycles <= perf_cycles + 16'd1;
         if (acc_req && (state != IDLE) && (perf_drops != '1))
            perf_drops <= perf_drops + 8'd1;
      end
   end
`endif

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Sequences the classification accelerator on behalf of the single-cycle CPU.
- On an ACC instruction it latches the operands Rm and Rn and issues one engine job per class.
- It collects the signed class scores, computes the argmax, and returns it on predict with acc_done held high.
- Sits between the CPU's Rm/Rn/acc_done/predict interface and the scoring engine.

Parameters:
- DATA_W, 16, width of operands and engine scores.
- NUM_CLASS, 10, maximum classes evaluated per request (2..15).
- PRED_W, 4, width of the predict output.
- TIMEOUT, 1023, maximum cycles to wait for eng_valid per class (fits a 10-bit counter).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- acc_req  in  1  one-cycle pulse, high while an ACC instruction executes.
- rm_i  in  DATA_W  Rm operand: feature base address.
- rn_i  in  DATA_W  Rn operand: [3:0] class count, 0 = NUM_CLASS.
- acc_done  out  1  result valid; level signal, polled by the CPU.
- predict  out  PRED_W  argmax class index, or 4'hF on error.
- busy  out  1  high from request acceptance until acc_done rises.
- err  out  1  last request timed out; sticky until the next accepted request.
- eng_start  out  1  one-cycle job start to the engine.
- eng_class  out  PRED_W  class index of the current job.
- eng_base  out  DATA_W  latched Rm, held stable for the whole request.
- eng_valid  in  1  one-cycle pulse; eng_score is valid in that cycle.
- eng_score  in  DATA_W  two's-complement class score.

Behaviour:
- Reset values: all outputs 0, state IDLE, best score = most-negative value, class counter = 0.
- States:
  - IDLE: on acc_req, latch rm_i into eng_base and compute the class limit n = (rn_i[3:0]==0 || rn_i[3:0]>NUM_CLASS) ? NUM_CLASS : rn_i[3:0]. In the same edge: clear acc_done and err, set busy, reset best to the most-negative value, clear the class counter, go to ISSUE.
  - ISSUE: assert eng_start for exactly one cycle with eng_class = class counter; clear the timeout counter; go to WAIT.
  - WAIT: on eng_valid, do a signed compare. If score > best (strict), update best and best index; ties keep the lower index. Then, if class == n-1, go to FIN; otherwise increment class and go to ISSUE. The timeout counter increments each WAIT cycle without eng_valid; reaching TIMEOUT sets err, forces predict = 4'hF and goes to FIN.
  - FIN: one cycle. Drive predict with the best index (unless err), set acc_done, clear busy, go to IDLE.
- Latency: 1 cycle to ISSUE, 2 + k_i cycles per class (k_i = engine latency), plus 1 FIN cycle.
- acc_done and predict are registered and held until the next accepted acc_req.
- acc_req while not IDLE: ignored, with no effect on the request in flight.
- eng_valid outside WAIT: ignored.
- eng_valid in the same cycle the timeout expires: the valid score wins and no timeout is recorded.
- Single-class request (n = 1): exactly one ISSUE/WAIT pass.
- rn_i bits [15:4] are ignored.
- Reset mid-operation returns to IDLE with all outputs at reset values; engine state is not the sequencer's concern.
- The CPU stops its own clock on halt; the sequencer runs on ungated clk_i.

Optional Feature:
- Macro ACC_SEQ_PERF_EN.
- When defined: adds output perf_cycles (16 bits), a saturating count of clk_i cycles from acceptance to FIN for the last request. It is cleared at acceptance, updated every busy cycle, and held after FIN. It also adds output perf_drops (8 bits), a saturating count of acc_req pulses ignored while busy; perf_drops is cleared only by reset.
- When undefined: neither port exists and there is no counter logic.

Decomposition:
- Shared package acc_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, FIN);
  - the ERR_PRED = 4'hF constant;
  - the most-negative score constant;
  - the class-limit width.
- One sub-module, acc_argmax_tracker: it holds best score and index, with inputs clear, valid, score and index, and the signed strict-greater compare. The FSM and timeout counter stay in the top module.

Test Plan:
- Request with rn=0 and scores 5,-3,9,9,2,0,1,1,-8,4, each returned after 3 cycles -> predict=2, acc_done=1, err=0, exactly 10 eng_start pulses, eng_base equal to rm.
- Request with rn=3 and scores -100,-50,-50 -> predict=1 (tie keeps the lower index), 3 eng_start pulses.
- Request with rn=4, engine silent on class 2 -> timeout after 1023 WAIT cycles, err=1, predict=4'hF, acc_done=1, no class-3 issue.
- Second acc_req pulse while busy -> first result unaffected; with ACC_SEQ_PERF_EN, perf_drops=1.
- rst_n low during WAIT of class 5, then a new request with rn=2 -> all outputs 0 during reset, and the new result comes from classes 0..1 only.
- Request with rn=15 and NUM_CLASS=10 -> clamped to 10 classes; the last eng_class is 9.
